three_a_minus_two_b_solver: RTL and testbench

Sequential inverse of the `3A - 2B` datapath: given a result `Y` and the operand `B`, recovers `A` such that `Y = 3A - 2B (mod 2^16)`. The block uses the fact that 3 is odd and therefore invertible mod 2^16, with 3^-1 = 0xAAAB. It computes `A = (Y + 2B) * 0xAAAB mod 2^16` with a 16-iteration shift-and-add multiplier and a start/busy/done handshake. It sits beside the combinational `3A - 2B` unit as its checker/decoder in the Experiment 3 arithmetic datapath.

---
 rtl/three_a_minus_two_b_solver_pkg.sv | 27 ++
 rtl/three_a_minus_two_b_solver_full_adder_16bit.sv | 30 +++
 rtl/three_a_minus_two_b_solver.sv | 109 ++++++++++
 tb/tb_three_a_minus_two_b_solver.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/three_a_minus_two_b_solver_pkg.sv
// Shared definitions for the 3A - 2B inverse solver.
// Contents:
//   WIDTH      - operand/result width (only 16 is supported)
//   INV3       - multiplicative inverse of 3 mod 2^WIDTH
//   ITERATIONS - shift-and-add iterations per solve
//   state_t    - solver FSM states
package three_a_minus_two_b_solver_pkg;

  localparam int WIDTH = 16;

  // 3 * 0xAAAB = 0x20001, which is 1 mod 2^16.
  localparam logic [WIDTH-1:0] INV3 = 16'hAAAB;

  localparam int ITERATIONS = 16;
  localparam int CNT_WIDTH  = $clog2(ITERATIONS);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam cnt_t LAST_CNT = cnt_t'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

endpackage

// File: rtl/three_a_minus_two_b_solver_full_adder_16bit.sv
// Ripple-carry adder used for the operand precompute and the accumulator.
// Ports:
//   a, b  in  WIDTH : addends
//   cin   in  1     : carry in
//   sum   out WIDTH : a + b + cin, mod 2^WIDTH
//   cout  out 1     : carry out of the top bit
module full_adder_16bit
  import three_a_minus_two_b_solver_pkg::*;
#(
  parameter int WIDTH = three_a_minus_two_b_solver_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/three_a_minus_two_b_solver.sv
// Recovers A from Y = 3A - 2B (mod 2^16) by computing
// A = (Y + 2B) * INV3 with a 16-iteration shift-and-add multiplier.
// Ports:
//   clk    in  1  : clock, rising edge
//   rst_n  in  1  : asynchronous active-low reset
//   start  in  1  : request, sampled in IDLE or DONE
//   Y      in  16 : result of 3A - 2B, sampled with start
//   B      in  16 : second operand, sampled with start
//   busy   out 1  : high while multiplying
//   done   out 1  : one-cycle pulse when A_out is updated
//   A_out  out 16 : recovered A, held until the next solve completes
module three_a_minus_two_b_solver
  import three_a_minus_two_b_solver_pkg::*;
#(
  parameter int               WIDTH = three_a_minus_two_b_solver_pkg::WIDTH,
  parameter logic [WIDTH-1:0] INV3  = three_a_minus_two_b_solver_pkg::INV3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] A_out
);

  state_t state_q, state_d;

  logic [WIDTH-1:0] acc, mcand, mplier;
  cnt_t             cnt;

  logic [WIDTH-1:0] two_b;
  logic [WIDTH-1:0] mcand_init;
  logic [WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0] acc_next;
  logic             unused_pre_carry;
  logic             unused_acc_carry;

  // Shift drops B[15]; the adder drops its carry, giving Y + 2B mod 2^16.
  assign two_b = B << 1;

  full_adder_16bit #(.WIDTH(WIDTH)) u_pre_add (
    .a    (Y),
    .b    (two_b),
    .cin  (1'b0),
    .sum  (mcand_init),
    .cout (unused_pre_carry)
  );

  full_adder_16bit #(.WIDTH(WIDTH)) u_acc_add (
    .a    (acc),
    .b    (mcand),
    .cin  (1'b0),
    .sum  (acc_sum),
    .cout (unused_acc_carry)
  );

  assign acc_next = mplier[0] ? acc_sum : acc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: DONE behaves like IDLE for accepting a new request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? MUL : IDLE;
      MUL:     state_d = (cnt == LAST_CNT) ? DONE : MUL;
      DONE:    state_d = start ? MUL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Multiplier datapath. A_out only moves on the final iteration so the
  // previous answer stays visible for the whole next solve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      A_out  <= '0;
    end else if (state_q == MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + cnt_t'(1);
      if (cnt == LAST_CNT) begin
        A_out <= acc_next;
      end
    end else if (start) begin
      acc    <= '0;
      mcand  <= mcand_init;
      mplier <= INV3;
      cnt    <= '0;
    end
  end

  assign busy = (state_q == MUL);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_three_a_minus_two_b_solver.sv
// Self-checking bench for three_a_minus_two_b_solver. Expected answers come
// from the arithmetic definition A = (Y + 2B) * inverse(3) mod 2^16, or
// from choosing A first and forming Y = 3A - 2B.
module tb_three_a_minus_two_b_solver;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] Y;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] A_out;

  int checks = 0;
  int errors = 0;

  three_a_minus_two_b_solver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .Y     (Y),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .A_out (A_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: (Y + 2B) * 0xAAAB, truncated to 16 bits.
  function automatic logic [15:0] model_a(input logic [15:0] y, input logic [15:0] b);
    int unsigned p;
    p = (int'(y) + 2 * int'(b)) * 32'hAAAB;
    return p[15:0];
  endfunction

  // Runs one solve from a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [15:0] y, input logic [15:0] b,
                        output int latency, output int busy_cycles,
                        output bit overlap, output bit timeout);
    Y = y;
    B = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    latency = 0;
    busy_cycles = 0;
    overlap = 1'b0;
    timeout = 1'b0;
    while (!done) begin
      if (busy) busy_cycles++;
      latency++;
      if (latency > 40) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (busy && done) overlap = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    Y = '0;
    B = '0;
    #12;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || A_out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_state: busy=%b done=%b A_out=%h, want 0 0 0000", busy, done, A_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] ys[5] = '{16'h0009, 16'hFFFF, 16'hFFFD, 16'h369C, 16'h0000};
    logic [15:0] bs[5] = '{16'h0003, 16'h0002, 16'h0000, 16'h8000, 16'h0000};
    logic [15:0] as[5] = '{16'h0005, 16'h0001, 16'hFFFF, 16'h1234, 16'h0000};
    int lat, bc;
    bit ov, to;
    for (int i = 0; i < 5; i++) begin
      run_op(ys[i], bs[i], lat, bc, ov, to);
      checks++;
      if (to || lat != 16) begin
        errors++;
        $display("[TB] FAIL directed_latency[%0d]: got %0d clocks (timeout=%b), want 16", i, lat, to);
      end
      checks++;
      if (bc != 16 || ov) begin
        errors++;
        $display("[TB] FAIL directed_busy[%0d]: busy cycles %0d overlap=%b, want 16 0", i, bc, ov);
      end
      checks++;
      if (A_out !== as[i]) begin
        errors++;
        $display("[TB] FAIL directed_result[%0d]: A_out=%h, want %h", i, A_out, as[i]);
      end
      checks++;
      if (model_a(ys[i], bs[i]) !== as[i]) begin
        errors++;
        $display("[TB] FAIL model_consistency[%0d]: model=%h, want %h", i, model_a(ys[i], bs[i]), as[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL done_width[%0d]: done=%b one cycle later, want 0", i, done);
      end
    end
  endtask

  task automatic test_ignore_start();
    int k;
    int pulses;
    int first_at;
    logic [15:0] result;
    Y = 16'h0009;
    B = 16'h0003;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    first_at = -1;
    result = 16'h0000;
    for (k = 0; k < 40; k++) begin
      if (done) begin
        if (pulses == 0) begin
          first_at = k;
          result = A_out;
        end
        pulses++;
      end
      if (k == 3 || k == 10) begin
        start = 1'b1;
        Y = 16'h1111 * 16'(k);
        B = 16'h0777;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (pulses != 1 || first_at != 16) begin
      errors++;
      $display("[TB] FAIL ignore_start_done: pulses=%0d at %0d, want 1 at 16", pulses, first_at);
    end
    checks++;
    if (result !== 16'h0005 || A_out !== 16'h0005) begin
      errors++;
      $display("[TB] FAIL ignore_start_result: A_out=%h held=%h, want 0005", result, A_out);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, gap;
    bit ov, to;
    logic [15:0] a2, b2, y2;
    a2 = 16'hBEEF;
    b2 = 16'h4321;
    y2 = 16'(3 * int'(a2) - 2 * int'(b2));
    run_op(16'hFFFF, 16'h0002, lat, bc, ov, to);
    checks++;
    if (to || A_out !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL b2b_first: A_out=%h timeout=%b, want 0001", A_out, to);
    end
    // In DONE: present the next request so it is taken at the DONE edge.
    Y = y2;
    B = b2;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || A_out !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL b2b_accept: busy=%b A_out=%h, want 1 0001", busy, A_out);
    end
    gap = 1;
    while (!done && gap < 40) begin
      gap++;
      @(negedge clk);
    end
    checks++;
    if (gap != 17) begin
      errors++;
      $display("[TB] FAIL b2b_spacing: second done %0d clocks after first, want 17", gap);
    end
    checks++;
    if (A_out !== a2) begin
      errors++;
      $display("[TB] FAIL b2b_second: A_out=%h, want %h", A_out, a2);
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat, bc;
    bit ov, to;
    bit saw_done;
    // Leave a known nonzero A_out first.
    run_op(16'h369C, 16'h8000, lat, bc, ov, to);
    @(negedge clk);
    Y = 16'hFFFD;
    B = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || A_out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_mul: busy=%b done=%b A_out=%h, want 0 0 0000", busy, done, A_out);
    end
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("[TB] FAIL reset_no_done: done pulsed after abort, want none");
    end
    run_op(16'h0009, 16'h0003, lat, bc, ov, to);
    checks++;
    if (to || lat != 16 || A_out !== 16'h0005) begin
      errors++;
      $display("[TB] FAIL reset_recover: A_out=%h latency=%0d, want 0005 16", A_out, lat);
    end
  endtask

  task automatic test_random();
    int lat, bc;
    bit ov, to;
    logic [15:0] a, b, y;
    for (int n = 0; n < 1000; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      y = 16'(3 * int'(a) - 2 * int'(b));
      run_op(y, b, lat, bc, ov, to);
      checks++;
      if (to || ov || lat != 16 || A_out !== a) begin
        errors++;
        $display("[TB] FAIL random[%0d]: Y=%h B=%h A_out=%h latency=%0d, want %h 16", n, y, b, A_out, lat, a);
      end
      if (($urandom & 1) == 0) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    @(negedge clk);
    test_reset_mid_mul();
    @(negedge clk);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
